present_iter: RTL and testbench

PRESENT_ITER -- requirements
Module: present_iter

---
 rtl/present_iter.sv | 201 ++++++++++++++++++++
 tb/tb_present_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/present_iter.sv
// Iterative PRESENT block cipher: one round and one key-schedule step per clock, 80- or 128-bit key.
// Defining PRESENT_DECRYPT_EN adds the mode port, the EXPAND state and the inverse datapath.
module present_iter #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] k,
    input  logic [63:0]      m,
`ifdef PRESENT_DECRYPT_EN
    input  logic             mode,
`endif
    input  logic             req,
    output logic [63:0]      c,
    output logic             ack
);

    localparam int          CNT_LSB  = (KEY_W == 128) ? 62 : 15;
    localparam logic [4:0]  LAST_I   = 5'(ROUNDS);
    localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C;

    generate
        if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
            $error("present_iter: KEY_W must be 80 or 128");
        end
        if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
            $error("present_iter: ROUNDS must be in 1..31");
        end
    endgenerate

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TAB[4*x +: 4];
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox(x[4*n +: 4]);
        return r;
    endfunction

    // Bit j moves to 16*j mod 63; bit 63 is fixed.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] r;
        r[63] = x[63];
        for (int j = 0; j < 63; j++) r[(16*j) % 63] = x[j];
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] kr, input logic [4:0] rc);
        logic [KEY_W-1:0] r;
        r = {kr[KEY_W-62:0], kr[KEY_W-1:KEY_W-61]};
        r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
        r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ rc;
        return r;
    endfunction

`ifdef PRESENT_DECRYPT_EN
    localparam logic [63:0] INV_SBOX_TAB = 64'hA970364BD21C8FE5;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TAB[4*x +: 4];
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] r;
        r[63] = x[63];
        for (int j = 0; j < 63; j++) r[j] = x[(16*j) % 63];
        return r;
    endfunction

    // Undoes key_fwd step by step in reverse order.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] kr, input logic [4:0] rc);
        logic [KEY_W-1:0] r;
        r = kr;
        r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ rc;
        r[KEY_W-1 -: 4] = inv_sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128) r[KEY_W-5 -: 4] = inv_sbox(r[KEY_W-5 -: 4]);
        return {r[60:0], r[KEY_W-1:61]};
    endfunction
`endif

    typedef enum logic [2:0] {
        IDLE,
        ROUND,
        DONE,
        WAIT_LO
`ifdef PRESENT_DECRYPT_EN
        , EXPAND
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [63:0]      data_reg;
    logic [KEY_W-1:0] key_reg;
    logic [4:0]       i;
    logic [63:0]      round_key;
    logic             round_last;

    assign round_key = key_reg[KEY_W-1 -: 64];

`ifdef PRESENT_DECRYPT_EN
    logic dec_r;
    assign round_last = dec_r ? (i == 5'd1) : (i == LAST_I);
`else
    assign round_last = (i == LAST_I);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
`ifdef PRESENT_DECRYPT_EN
                    state_nxt = mode ? EXPAND : ROUND;
`else
                    state_nxt = ROUND;
`endif
                end
            end
`ifdef PRESENT_DECRYPT_EN
            EXPAND:  if (i == LAST_I) state_nxt = ROUND;
`endif
            ROUND:   if (round_last) state_nxt = DONE;
            DONE:    state_nxt = WAIT_LO;
            WAIT_LO: if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, key register and round counter advance according to the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            key_reg  <= '0;
            i        <= '0;
            c        <= '0;
            ack      <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
            dec_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        data_reg <= m;
                        key_reg  <= k;
                        i        <= 5'd1;
`ifdef PRESENT_DECRYPT_EN
                        dec_r    <= mode;
`endif
                    end
                end
`ifdef PRESENT_DECRYPT_EN
                EXPAND: begin
                    key_reg <= key_fwd(key_reg, i);
                    if (i != LAST_I) i <= i + 5'd1;
                end
`endif
                ROUND: begin
`ifdef PRESENT_DECRYPT_EN
                    if (dec_r) begin
                        data_reg <= inv_sbox_layer(inv_p_layer(data_reg ^ round_key));
                        key_reg  <= key_inv(key_reg, i);
                        if (!round_last) i <= i - 5'd1;
                    end else begin
                        data_reg <= p_layer(sbox_layer(data_reg ^ round_key));
                        key_reg  <= key_fwd(key_reg, i);
                        if (!round_last) i <= i + 5'd1;
                    end
`else
                    data_reg <= p_layer(sbox_layer(data_reg ^ round_key));
                    key_reg  <= key_fwd(key_reg, i);
                    if (!round_last) i <= i + 5'd1;
`endif
                end
                DONE: begin
                    c   <= data_reg ^ round_key;
                    ack <= 1'b1;
                end
                WAIT_LO: begin
                    if (!req) ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_iter.sv
// Bench for present_iter: known-answer vectors plus random blocks against a behavioural PRESENT model.
// The decrypt steps are compiled in only when PRESENT_DECRYPT_EN is defined.
module tb_present_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [79:0]  k80 = '0;
    logic [63:0]  m80 = '0;
    logic         req80 = 1'b0;
    logic [63:0]  c80;
    logic         ack80;
    logic [127:0] k128 = '0;
    logic [63:0]  m128 = '0;
    logic         req128 = 1'b0;
    logic [63:0]  c128;
    logic         ack128;
`ifdef PRESENT_DECRYPT_EN
    logic         mode80 = 1'b0;
    logic         mode128 = 1'b0;
`endif

    int checks_total = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    logic [63:0] sbox_tab = 64'h21748FE3DA09B65C;

    always #5 clk = ~clk;

    present_iter #(.KEY_W(80), .ROUNDS(31)) u_dut80 (
        .clk(clk), .rst_n(rst_n), .k(k80), .m(m80),
`ifdef PRESENT_DECRYPT_EN
        .mode(mode80),
`endif
        .req(req80), .c(c80), .ack(ack80)
    );

    present_iter #(.KEY_W(128), .ROUNDS(31)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .k(k128), .m(m128),
`ifdef PRESENT_DECRYPT_EN
        .mode(mode128),
`endif
        .req(req128), .c(c128), .ack(ack128)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference PRESENT encryption written directly from the cipher description.
    function automatic logic [63:0] model_enc(input logic [127:0] key, input int kw, input logic [63:0] pt);
        logic [127:0] kr;
        logic [127:0] mask;
        logic [63:0]  s;
        logic [63:0]  t;
        logic [63:0]  tab;
        tab  = sbox_tab;
        kr   = key;
        mask = (kw == 128) ? {128{1'b1}} : ((128'd1 << 80) - 128'd1);
        s    = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ 64'(kr >> (kw - 64));
            for (int n = 0; n < 16; n++) s[4*n +: 4] = tab[4*s[4*n +: 4] +: 4];
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (16*b) % 63] = s[b];
            s = t;
            kr = ((kr << 61) | (kr >> (kw - 61))) & mask;
            kr[kw-1 -: 4] = tab[4*kr[kw-1 -: 4] +: 4];
            if (kw == 128) begin
                kr[123:120] = tab[4*kr[123:120] +: 4];
                kr[66:62]   = kr[66:62] ^ 5'(r);
            end else begin
                kr[19:15]   = kr[19:15] ^ 5'(r);
            end
        end
        return s ^ 64'(kr >> (kw - 64));
    endfunction

    task automatic wait_ack80(input bit toggle, output int cycles);
        @(posedge clk); #1;
        cycles = 0;
        while (ack80 !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            if (toggle) begin
                k80 = ~k80;
                m80 = ~m80;
            end
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic applyStimulus80(input logic [79:0] key, input logic [63:0] blk, input bit toggle, output int cycles);
        @(negedge clk);
        k80 = key; m80 = blk; req80 = 1'b1;
        wait_ack80(toggle, cycles);
    endtask

    task automatic release80();
        @(negedge clk); req80 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus128(input logic [127:0] key, input logic [63:0] blk, output int cycles);
        @(negedge clk);
        k128 = key; m128 = blk; req128 = 1'b1;
        @(posedge clk); #1;
        cycles = 0;
        while (ack128 !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        @(negedge clk); req128 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        logic [79:0]  rk80;
        logic [127:0] rk128;
        logic [63:0]  rm;
        logic [63:0]  exp_c;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_c80",    c80,          64'h0);
        check("reset_ack80",  64'(ack80),   64'h0);
        check("reset_c128",   c128,         64'h0);
        check("reset_ack128", 64'(ack128),  64'h0);
        rst_n = 1'b1;

        applyStimulus80(80'h0, 64'h0, 1'b0, cyc);
        check("kat80_zero_c",       c80,        64'h5579C1387B228445);
        check("kat80_zero_ack",     64'(ack80), 64'h1);
        check("kat80_zero_latency", 64'(cyc),   64'd32);
        release80();
        check("kat80_zero_ack_clr", 64'(ack80), 64'h0);
        check("kat80_zero_c_hold",  c80,        64'h5579C1387B228445);

        @(negedge clk); #1 req80 = 1'b1; #2 req80 = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("short_pulse_ack", 64'(ack80), 64'h0);
        check("short_pulse_c",   c80,        64'h5579C1387B228445);

        applyStimulus80({80{1'b1}}, {64{1'b1}}, 1'b0, cyc);
        check("kat80_ones_c", c80, 64'h3333DCD3213210D2);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("kat80_ones_ack_hold", 64'(ack80), 64'h1);
        end
        check("kat80_ones_c_hold", c80, 64'h3333DCD3213210D2);
        release80();
        check("kat80_ones_ack_clr", 64'(ack80), 64'h0);

        applyStimulus80({80{1'b1}}, 64'h0, 1'b1, cyc);
        check("toggle_inputs_c",       c80,      64'hE72C46C0F5945049);
        check("toggle_inputs_latency", 64'(cyc), 64'd32);
        release80();

        for (int n = 0; n < 4; n++) begin
            rk80 = {16'($urandom), $urandom, $urandom};
            rm   = {$urandom, $urandom};
            applyStimulus80(rk80, rm, 1'b0, cyc);
            check("rand80_ack", 64'(ack80), 64'h1);
            check("rand80_c",   c80,        model_enc({48'h0, rk80}, 80, rm));
            release80();
        end

        @(negedge clk);
        k80 = 80'h0; m80 = 64'h0; req80 = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop_reset_ack", 64'(ack80), 64'h0);
        check("midop_reset_c",   c80,        64'h0);
        @(negedge clk); rst_n = 1'b1;
        wait_ack80(1'b0, cyc);
        check("after_reset_c",       c80,      64'h5579C1387B228445);
        check("after_reset_latency", 64'(cyc), 64'd32);
        release80();

        applyStimulus128(128'h0, 64'h0, cyc);
        check("kat128_zero_c",       c128,     64'h96DB702A2E6900AF);
        check("kat128_zero_latency", 64'(cyc), 64'd32);
        rk128 = {$urandom, $urandom, $urandom, $urandom};
        rm    = {$urandom, $urandom};
        applyStimulus128(rk128, rm, cyc);
        check("rand128_c", c128, model_enc(rk128, 128, rm));

`ifdef PRESENT_DECRYPT_EN
        mode80 = 1'b1;
        applyStimulus80(80'h0, 64'h5579C1387B228445, 1'b0, cyc);
        check("dec80_zero_c",       c80,      64'h0);
        check("dec80_zero_latency", 64'(cyc), 64'd63);
        release80();
        for (int n = 0; n < 2; n++) begin
            rk80  = {16'($urandom), $urandom, $urandom};
            rm    = {$urandom, $urandom};
            exp_c = model_enc({48'h0, rk80}, 80, rm);
            mode80 = 1'b0;
            applyStimulus80(rk80, rm, 1'b0, cyc);
            check("roundtrip_enc_c", c80, exp_c);
            release80();
            mode80 = 1'b1;
            applyStimulus80(rk80, exp_c, 1'b0, cyc);
            check("roundtrip_dec_c", c80, rm);
            release80();
        end
        mode80 = 1'b0;
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
